pim_input_buffer: RTL and testbench
===================================

Name: pim_input_buffer

Overview:
- Upstream feeder for the PIM macro.
- Collects 32-bit words written by the RISC-V peripheral bus and packs them into 1024-bit rows.
- Presents each completed row to the PIM array over a valid/ready handshake.
- Double-banked, so the bus can fill one row while the PIM consumes the other.
- Byte ordering is the exact inverse of the downstream output buffer: a row read back word-by-word appears in the same byte order it was written.

Parameters:
- DATA_W, 32, bus word width in bits.
- ROW_W, 1024, PIM row width in bits; must be a multiple of DATA_W.
- WORDS_PER_ROW, ROW_W/DATA_W (32), derived; words per row.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- clear_i  in  1  synchronous clear: empties both banks, zeroes counters, clears ovf_o.
- wr_en_i  in  1  bus write strobe, one word per cycle.
- wr_data_i  in  32  bus write word.
- wr_ready_o  out  1  a fill bank is available; writes are accepted only when high.
- close_i  in  1  close the current partial row (zero-padded) and mark it full.
- row_valid_o  out  1  a full row is presented on row_o.
- row_ready_i  in  1  PIM accepts the row.
- row_o  out  1024  row data to the PIM.
- row_words_o  out  6  number of valid words in the presented row (1..32).
- ovf_o  out  1  sticky flag: a write was attempted while wr_ready_o was low.
- fill_cnt_o  out  5  words already written into the current fill bank.

Behaviour:
- Reset values:
  - Both banks EMPTY and zero; wbank=0, rbank=0.
  - fill_cnt_o=0, row_valid_o=0, row_o=0, row_words_o=0, ovf_o=0, wr_ready_o=1.
- Per-bank state machine, EMPTY -> FILLING -> FULL -> EMPTY:
  - EMPTY -> FILLING: first accepted write.
  - FILLING -> FULL: the 32nd word is accepted, or close_i with fill_cnt>0.
  - FULL -> EMPTY: row_valid_o && row_ready_i while the bank is rbank.
- Packing:
  - Word k, byte j (wr_data_i[8j+7:8j]) lands at row bits [1023-32k-8j -: 8].
  - So word 0 byte 0 occupies row[1023:1016].
  - On close, unwritten words read as zero.
- Write acceptance:
  - A write is accepted when wr_en_i && wr_ready_o. The word is stored at index fill_cnt and fill_cnt increments.
  - After word 31 (or a close), fill_cnt resets to 0 and wbank toggles.
  - wr_ready_o = bank[wbank] != FULL.
- Write rejection: wr_en_i while wr_ready_o=0 drops the word and sets ovf_o. ovf_o holds until clear_i or reset.
- Output side:
  - row_valid_o = bank[rbank]==FULL.
  - row_o and row_words_o come combinationally from bank[rbank]; both are 0 when row_valid_o=0.
  - On handshake, the bank is zeroed, set EMPTY, and rbank toggles.
  - row_o must remain stable while row_valid_o=1 and row_ready_i=0.
- Latency: a row is valid the cycle after its completing write or close.
- Simultaneous events:
  - Output handshake on bank A in the same cycle as a completing write to bank B: both take effect.
  - Handshake on the bank that wbank points to (both banks full): wr_ready_o rises the next cycle, not combinationally.
  - wr_en_i and close_i in the same cycle: the word is written first, then the row closes with fill_cnt+1 words. If that word was word 31, the row is simply full.
  - close_i with fill_cnt=0 and no write: ignored (no empty rows are emitted).
- clear_i has priority over all other inputs.
- Reset mid-operation discards all data asynchronously.

Optional Feature:
- Macro: PIM_INBUF_DOUBLE_BANK_EN.
- Defined: two banks, as described above.
- Undefined:
  - A single bank; wbank and rbank are tied to 0.
  - wr_ready_o is low from row completion until the handshake completes, so the bus stalls for the full PIM consumption time.
  - Port list is unchanged.

Decomposition:
- Package pim_buf_pkg holds:
  - PIM_ROW_W=1024, PIM_WORD_W=32, PIM_WORDS_PER_ROW=32.
  - typedef enum logic [1:0] {BANK_EMPTY, BANK_FILLING, BANK_FULL} bank_state_e.
  - typedef logic [1023:0] pim_row_t.
  - A function word_lane(k) returning the row MSB index for word k.
- Sub-module pim_inbuf_bank:
  - Contains one row register, its state machine and its valid-word count.
  - Instantiated once or twice depending on PIM_INBUF_DOUBLE_BANK_EN.

Test Plan:
- Full row: write words 0x03020100 + 0x04040404*k for k=0..31, row_ready_i=0 -> next cycle row_valid_o=1, row_o[1023:992]=0x00010203, row_words_o=32, wr_ready_o=1 (bank 1 free).
- Back-pressure: fill 64 words with row_ready_i=0 -> wr_ready_o=0 after word 63. A 65th write sets ovf_o=1 and row_o is unchanged. Pulse row_ready_i -> wr_ready_o=1 the next cycle.
- Partial close: write 3 words 0xAABBCCDD, then close_i -> row_o[1023:928]=0xDDCCBBAA repeated 3x, remaining bits 0, row_words_o=3.
- Same-cycle edges:
  - close_i with fill_cnt=0 -> no row_valid_o.
  - wr_en_i+close_i on word 5 -> row_words_o=6.
- Simultaneous handshake and completing write into the other bank -> the next row is valid the following cycle with no bubble; rbank alternates 0,1,0.
- clear_i while both banks are full and ovf_o=1 -> next cycle row_valid_o=0, wr_ready_o=1, ovf_o=0, fill_cnt_o=0. The same holds for an asynchronous rst_ni pulse mid-row.

Source files
------------

// File: rtl/pim_buf_pkg.sv
// Shared constants, types and lane helpers for the PIM input buffer.
// Row layout: word k occupies bits [word_lane(k) -: 32], byte 0 in the top byte.
package pim_buf_pkg;

    localparam int PIM_ROW_W         = 1024;
    localparam int PIM_WORD_W        = 32;
    localparam int PIM_WORDS_PER_ROW = PIM_ROW_W / PIM_WORD_W;
    localparam int PIM_CNT_W         = 6;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_e;

    typedef logic [PIM_ROW_W-1:0] pim_row_t;

    // MSB index of word k inside a row.
    function automatic logic [9:0] word_lane(input logic [4:0] k);
        return 10'(PIM_ROW_W - 1 - int'(k) * PIM_WORD_W);
    endfunction

    // Byte 0 of the bus word goes to the most significant byte of its lane.
    function automatic logic [PIM_WORD_W-1:0] swap_bytes(input logic [PIM_WORD_W-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/pim_inbuf_bank.sv
// One row register of the PIM input buffer with its EMPTY/FILLING/FULL state machine
// and valid-word count; state_o exposes the FSM state for observation.
module pim_inbuf_bank
    import pim_buf_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  wr_i,
    input  logic [PIM_WORD_W-1:0] wr_data_i,
    input  logic                  close_i,
    input  logic                  pop_i,
    output bank_state_e           state_o,
    output logic                  done_o,
    output pim_row_t              row_o,
    output logic [PIM_CNT_W-1:0]  words_o
);

    localparam logic [PIM_CNT_W-1:0] LAST_IDX = PIM_CNT_W'(PIM_WORDS_PER_ROW - 1);

    bank_state_e           state_q, state_d;
    logic                  done;
    logic                  wr_ok;
    logic                  drain;
    pim_row_t              row_q;
    logic [PIM_CNT_W-1:0]  cnt_q;

    // A write into a FULL bank can never happen; the guard just keeps the row safe.
    assign wr_ok = wr_i && !clear_i && (state_q != BANK_FULL);
    assign drain = pop_i && !clear_i && (state_q == BANK_FULL);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= BANK_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        done    = 1'b0;
        state_d = state_q;
        if (!clear_i && state_q != BANK_FULL) begin
            if (wr_i) begin
                done = close_i || (cnt_q == LAST_IDX);
            end else begin
                done = close_i && (state_q == BANK_FILLING);
            end
        end
        if (clear_i) begin
            state_d = BANK_EMPTY;
        end else begin
            case (state_q)
                BANK_EMPTY, BANK_FILLING: begin
                    if (done) begin
                        state_d = BANK_FULL;
                    end else if (wr_i) begin
                        state_d = BANK_FILLING;
                    end
                end
                BANK_FULL: begin
                    if (pop_i) begin
                        state_d = BANK_EMPTY;
                    end
                end
                default: state_d = BANK_EMPTY;
            endcase
        end
    end

    always_comb begin
        state_o = state_q;
        done_o  = done;
        row_o   = row_q;
        words_o = cnt_q;
    end

    // Rows are zeroed on drain so a later close pads unwritten words with zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            row_q <= '0;
            cnt_q <= '0;
        end else if (clear_i || drain) begin
            row_q <= '0;
            cnt_q <= '0;
        end else if (wr_ok) begin
            row_q[word_lane(cnt_q[4:0]) -: PIM_WORD_W] <= swap_bytes(wr_data_i);
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/pim_input_buffer.sv
// Packs 32-bit bus words into 1024-bit PIM rows and hands them over valid/ready.
// Define PIM_INBUF_DOUBLE_BANK_EN for two ping-pong banks; otherwise a single bank.
//
// Handshake: a row transfers on the rising clk_i edge where row_valid_o && row_ready_i;
// row_o/row_words_o hold steady while row_valid_o is high and row_ready_i is low, and a
// bus word transfers on the edge where wr_en_i && wr_ready_o.
module pim_input_buffer
    import pim_buf_pkg::*;
#(
    parameter int DATA_W = PIM_WORD_W,
    parameter int ROW_W  = PIM_ROW_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_ready_o,
    input  logic              close_i,
    output logic              row_valid_o,
    input  logic              row_ready_i,
    output logic [ROW_W-1:0]  row_o,
    output logic [5:0]        row_words_o,
    output logic              ovf_o,
    output logic [4:0]        fill_cnt_o
);

`ifdef PIM_INBUF_DOUBLE_BANK_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    bank_state_e          st    [NB];
    logic                 done  [NB];
    pim_row_t             row   [NB];
    logic [PIM_CNT_W-1:0] words [NB];

    logic [NB-1:0] bank_wr;
    logic [NB-1:0] bank_close;
    logic [NB-1:0] bank_pop;

    logic wbank;
    logic rbank;
    logic wr_acc;
    logic pop;
    logic ovf_q;

    assign wr_ready_o  = (st[wbank] != BANK_FULL);
    assign row_valid_o = (st[rbank] == BANK_FULL);
    assign wr_acc      = wr_en_i && wr_ready_o && !clear_i;
    assign pop         = row_valid_o && row_ready_i && !clear_i;

    always_comb begin
        bank_wr           = '0;
        bank_close        = '0;
        bank_pop          = '0;
        bank_wr[wbank]    = wr_acc;
        bank_close[wbank] = close_i && !clear_i;
        bank_pop[rbank]   = pop;
    end

    for (genvar b = 0; b < NB; b++) begin : g_bank
        pim_inbuf_bank u_bank (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .clear_i   (clear_i),
            .wr_i      (bank_wr[b]),
            .wr_data_i (wr_data_i),
            .close_i   (bank_close[b]),
            .pop_i     (bank_pop[b]),
            .state_o   (st[b]),
            .done_o    (done[b]),
            .row_o     (row[b]),
            .words_o   (words[b])
        );
    end

`ifdef PIM_INBUF_DOUBLE_BANK_EN
    // Fill side advances when its bank completes; drain side advances on each handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wbank <= 1'b0;
            rbank <= 1'b0;
        end else if (clear_i) begin
            wbank <= 1'b0;
            rbank <= 1'b0;
        end else begin
            if (done[wbank]) begin
                wbank <= ~wbank;
            end
            if (pop) begin
                rbank <= ~rbank;
            end
        end
    end
`else
    assign wbank = 1'b0;
    assign rbank = 1'b0;
`endif

    always_comb begin
        row_o       = '0;
        row_words_o = '0;
        fill_cnt_o  = '0;
        if (row_valid_o) begin
            row_o       = row[rbank];
            row_words_o = words[rbank];
        end
        if (st[wbank] == BANK_FILLING) begin
            fill_cnt_o = words[wbank][4:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
        end else if (clear_i) begin
            ovf_q <= 1'b0;
        end else if (wr_en_i && !wr_ready_o) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf_o = ovf_q;

endmodule

// File: tb/tb_pim_input_buffer.sv
// Directed bench for pim_input_buffer; expectations follow PIM_INBUF_DOUBLE_BANK_EN.
module tb_pim_input_buffer;

`ifdef PIM_INBUF_DOUBLE_BANK_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          clear_i;
    logic          wr_en_i;
    logic [31:0]   wr_data_i;
    logic          wr_ready_o;
    logic          close_i;
    logic          row_valid_o;
    logic          row_ready_i;
    logic [1023:0] row_o;
    logic [5:0]    row_words_o;
    logic          ovf_o;
    logic [4:0]    fill_cnt_o;

    int errors = 0;
    int checks = 0;
    logic [31:0] wq [64];

    pim_input_buffer dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .wr_en_i     (wr_en_i),
        .wr_data_i   (wr_data_i),
        .wr_ready_o  (wr_ready_o),
        .close_i     (close_i),
        .row_valid_o (row_valid_o),
        .row_ready_i (row_ready_i),
        .row_o       (row_o),
        .row_words_o (row_words_o),
        .ovf_o       (ovf_o),
        .fill_cnt_o  (fill_cnt_o)
    );

    // clock
    initial forever #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_row(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        int bad;
        checks++;
        assert (obs === exp) else begin
            errors++;
            bad = 0;
            for (int k = 31; k >= 0; k--) begin
                if (obs[32*k +: 32] !== exp[32*k +: 32]) bad = 31 - k;
            end
            $error("FAIL %s: row word %0d observed=%08h expected=%08h", tag, bad,
                   obs[1023-32*bad -: 32], exp[1023-32*bad -: 32]);
        end
    endtask

    // Reference packing: word k byte j lands at row[1023-32k-8j -: 8].
    function automatic logic [1023:0] pack(input int base, input int n);
        logic [1023:0] r;
        r = '0;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 4; j++) begin
                r[1023 - 32*k - 8*j -: 8] = wq[base + k][8*j +: 8];
            end
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic put_word(input logic [31:0] d);
        wr_en_i   = 1'b1;
        wr_data_i = d;
        tick();
        wr_en_i   = 1'b0;
    endtask

    task automatic pop_row();
        row_ready_i = 1'b1;
        tick();
        row_ready_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0; clear_i = 1'b0; wr_en_i = 1'b0; wr_data_i = '0;
        close_i = 1'b0; row_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_valid", row_valid_o, 0);
        chk("rst_ready", wr_ready_o, 1);
        chk("rst_ovf", ovf_o, 0);
        chk("rst_fill", fill_cnt_o, 0);
        chk("rst_words", row_words_o, 0);
        chk_row("rst_row", row_o, '0);
        rst_ni = 1'b1;
        tick();

        // full row
        for (int k = 0; k < 64; k++) wq[k] = 32'h03020100 + 32'h04040404 * 32'(k);
        for (int k = 0; k < 5; k++) put_word(wq[k]);
        chk("fill5_cnt", fill_cnt_o, 5);
        chk("fill5_valid", row_valid_o, 0);
        for (int k = 5; k < 32; k++) put_word(wq[k]);
        chk("full_valid", row_valid_o, 1);
        chk("full_words", row_words_o, 32);
        chk("full_word0", row_o[1023:992], 64'h00010203);
        chk("full_word1", row_o[991:960], 64'h04050607);
        chk_row("full_row", row_o, pack(0, 32));
        chk("full_ready", wr_ready_o, DBL ? 64'd1 : 64'd0);
        chk("full_fill", fill_cnt_o, 0);
        chk("full_ovf", ovf_o, 0);

        // back-pressure
        for (int k = 32; k < 64; k++) put_word(wq[k]);
        chk("bp_ready", wr_ready_o, 0);
        chk("bp_ovf64", ovf_o, DBL ? 64'd0 : 64'd1);
        chk_row("bp_row64", row_o, pack(0, 32));
        put_word(32'hDEADBEEF);
        chk("bp_ovf65", ovf_o, 1);
        chk_row("bp_row65", row_o, pack(0, 32));
        row_ready_i = 1'b1;
        #1;
        chk("bp_ready_comb", wr_ready_o, 0);
        tick();
        row_ready_i = 1'b0;
        chk("bp_ready_next", wr_ready_o, 1);
        chk("bp_next_valid", row_valid_o, DBL ? 64'd1 : 64'd0);
        chk("bp_next_words", row_words_o, DBL ? 64'd32 : 64'd0);
        chk_row("bp_next_row", row_o, DBL ? pack(32, 32) : '0);
        pop_row();
        chk("bp_drained", row_valid_o, 0);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("bp_clear_ovf", ovf_o, 0);

        // partial close
        for (int k = 0; k < 3; k++) wq[k] = 32'hAABBCCDD;
        for (int k = 0; k < 3; k++) put_word(wq[k]);
        chk("part_fill", fill_cnt_o, 3);
        chk("part_valid0", row_valid_o, 0);
        close_i = 1'b1;
        tick();
        close_i = 1'b0;
        chk("part_valid", row_valid_o, 1);
        chk("part_words", row_words_o, 3);
        chk_row("part_row", row_o, {96'hDDCCBBAA_DDCCBBAA_DDCCBBAA, 928'd0});
        chk("part_fill0", fill_cnt_o, 0);
        pop_row();
        chk("part_drained", row_valid_o, 0);

        // close with nothing written
        close_i = 1'b1;
        tick();
        close_i = 1'b0;
        chk("empty_close_valid", row_valid_o, 0);
        tick();
        chk("empty_close_valid2", row_valid_o, 0);
        chk("empty_close_fill", fill_cnt_o, 0);

        // write + close on word 5
        for (int k = 0; k < 6; k++) wq[k] = 32'h11223300 + 32'(k);
        for (int k = 0; k < 5; k++) put_word(wq[k]);
        close_i = 1'b1;
        put_word(wq[5]);
        close_i = 1'b0;
        chk("wc_valid", row_valid_o, 1);
        chk("wc_words", row_words_o, 6);
        chk_row("wc_row", row_o, pack(0, 6));
        chk("wc_fill", fill_cnt_o, 0);
        pop_row();

        // handshake concurrent with completing write into the other bank
        for (int k = 0; k < 64; k++) wq[k] = 32'hA5000000 ^ (32'h01010101 * 32'(k));
        for (int k = 0; k < 32; k++) put_word(wq[k]);
        chk("sim_a_valid", row_valid_o, 1);
        for (int k = 32; k < 63; k++) put_word(wq[k]);
        row_ready_i = 1'b1;
        put_word(wq[63]);
        row_ready_i = 1'b0;
        chk("sim_b_valid", row_valid_o, DBL ? 64'd1 : 64'd0);
        chk("sim_b_words", row_words_o, DBL ? 64'd32 : 64'd0);
        chk_row("sim_b_row", row_o, DBL ? pack(32, 32) : '0);
        chk("sim_ovf", ovf_o, DBL ? 64'd0 : 64'd1);
        chk("sim_ready", wr_ready_o, 1);
        pop_row();
        chk("sim_b_drained", row_valid_o, 0);
        wq[0] = 32'hC0FFEE00;
        close_i = 1'b1;
        put_word(wq[0]);
        close_i = 1'b0;
        chk("sim_c_words", row_words_o, 1);
        chk_row("sim_c_row", row_o, pack(0, 1));
        pop_row();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;

        // clear while full with overflow
        for (int k = 0; k < 64; k++) put_word(32'h5A5A0000 + 32'(k));
        put_word(32'h0BADF00D);
        chk("clr_pre_ovf", ovf_o, 1);
        chk("clr_pre_valid", row_valid_o, 1);
        chk("clr_pre_ready", wr_ready_o, 0);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("clr_valid", row_valid_o, 0);
        chk("clr_ready", wr_ready_o, 1);
        chk("clr_ovf", ovf_o, 0);
        chk("clr_fill", fill_cnt_o, 0);
        chk_row("clr_row", row_o, '0);

        // asynchronous reset mid-row
        for (int k = 0; k < 10; k++) put_word(32'h77770000 + 32'(k));
        chk("arst_pre_fill", fill_cnt_o, 10);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_fill", fill_cnt_o, 0);
        chk("arst_ready", wr_ready_o, 1);
        chk("arst_valid", row_valid_o, 0);
        chk("arst_ovf", ovf_o, 0);
        #1 rst_ni = 1'b1;
        tick();
        wq[0] = 32'h12345678;
        close_i = 1'b1;
        put_word(wq[0]);
        close_i = 1'b0;
        chk("arst_after_words", row_words_o, 1);
        chk_row("arst_after_row", row_o, pack(0, 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
